ravens_pkt_decoder: RTL and testbench
=====================================

# ravens_pkt_decoder

Reassembles the stream of 32-bit RAVENS packets produced by the event-to-RAVENS serializer back into full DVS events: X address, Y address, polarity and 47-bit microsecond timestamp. It sits at the RAVENS-facing end of loopback and readback paths. There it consumes packets with a valid/ready handshake and presents one decoded event per three packets on a registered valid/ready output.

## Interface
- `X_BITS`, default `DVS_X_ADDR_BITS` (9): event X address width.
- `Y_BITS`, default `DVS_Y_ADDR_BITS` (9): event Y address width.
- `TS_BITS`, default `TIMESTAMP_US_BITS` (47): timestamp width; must equal 11+30+6.
- `clk  in  1`: single clock; all logic on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `pkt_data  in  RAVENS_PKT_BITS (32)`: incoming RAVENS packet.
- `pkt_valid  in  1`: packet present.
- `pkt_ready  out  1`: decoder accepts the packet this cycle.
- `event_x  out  X_BITS`: decoded X address.
- `event_y  out  Y_BITS`: decoded Y address.
- `event_pol  out  1`: decoded polarity.
- `event_ts  out  TS_BITS`: decoded timestamp (µs).
- `event_valid  out  1`: decoded event held on outputs.
- `event_ready  in  1`: downstream accepts the event.
- `seq_err  out  1`: one-cycle pulse on a framing error (only meaningful with checking compiled in).

## Operation
- Packet format, 3 words per event, marker in [31:30]:
  - Word 0: marker `2'b01`, [29:21] x, [20:12] y, [11] pol, [10:0] ts[46:36].
  - Word 1: marker `2'b10`, [29:0] ts[35:6].
  - Word 2: marker `2'b11`, [29:24] ts[5:0], [23:0] reserved, zero.
- A packet transfer occurs when `pkt_valid && pkt_ready`.
- FSM states are `S_W0`, `S_W1`, `S_W2`:
  - A transfer advances S_W0→S_W1→S_W2→S_W0.
  - Fields are captured into a partial register as each word arrives.
- On the word-2 transfer the full event is loaded into the output register, and `event_valid` sets the next cycle.
- `event_valid` clears on `event_valid && event_ready` unless a new word-2 transfer loads the register in the same cycle.
- `pkt_ready = (state != S_W2) || !event_valid || event_ready`:
  - Words 0 and 1 are always accepted.
  - Word 2 stalls only while the output is full and not being drained.
- Output fields remain stable while `event_valid && !event_ready`.

## Timing
- Reset values:
  - `event_valid`=0, `seq_err`=0.
  - All event fields 0.
  - State `S_W0`.
  - `pkt_ready`=1 during and after reset.
- Reset mid-event discards the partial event and any held output.
- Latency: `event_valid` rises 1 cycle after the word-2 transfer.
- Peak throughput: 1 event per 3 cycles with `event_ready` held high. Back-to-back events require no bubble.
- Simultaneous word-2 load and output drain in the same cycle: the new event replaces the old one, and `event_valid` stays 1.

## Configuration
- Macro: `RAVENS_DEC_CHECK_EN`.
- Defined: each word's marker is compared against the current state.
  - On mismatch, `seq_err` pulses the next cycle and the partial event is dropped.
  - If the offending word carries marker `01`, it is taken as a new word 0 (state→S_W1). Otherwise state→S_W0.
  - Nonzero reserved bits in word 2 pulse `seq_err` and emit no event.
- Undefined: markers and reserved bits are ignored, assembly is purely positional, and `seq_err` is tied 0.

## Structure
- Add to `dvs_ravens_pkg`:
  - `dvs_event_t` packed struct {x, y, pol, ts}.
  - Marker constants `RAVENS_MARK_W0/W1/W2`.
  - Field bit-position localparams.
  - `ravens_dec_state_t` enum.
- These package items are shared with the serializer so the encode and decode sides cannot diverge.
- Single module; no sub-module.

## Test plan
- Single event: words 0x6B303FFF, 0xBFFFFFFF, 0xFF000000 → x=345, y=259, pol=1, ts=47'h7FFF_FFFF_FFFF; `event_valid` rises one cycle after word 2.
- 10 random events streamed back-to-back with `event_ready`=1 → 10 events, each 3 cycles apart, fields match the serializer model.
- `event_ready`=0 for 20 cycles after the first event, with a second event's packets queued:
  - Words 0 and 1 are accepted, then `pkt_ready`=0 at word 2.
  - First event holds stable.
  - After release, the second event follows.
- `rst` asserted after word 1 → no event emitted; the next 3 valid words decode correctly.
- With `RAVENS_DEC_CHECK_EN`:
  - Sequence 0x6B303FFF, 0x6B303FFF, 0xBFFFFFFF, 0xFF000000 → one `seq_err` pulse and exactly one event (x=345).
  - Word 2 = 0xFF000001 → `seq_err` pulse, no event.
- Without the macro, word 2 = 0xFF000001 decodes normally and `seq_err` stays 0.

Source files
------------

// File: rtl/dvs_ravens_pkg.sv
// Shared RAVENS packet definitions for the event serializer and decoder.
// Keeping the word layout here means both sides read the same field
// positions and markers.
package dvs_ravens_pkg;

  localparam int RAVENS_PKT_BITS   = 32;
  localparam int DVS_X_ADDR_BITS   = 9;
  localparam int DVS_Y_ADDR_BITS   = 9;
  localparam int TIMESTAMP_US_BITS = 47;

  // The timestamp is split across the three words as hi / mid / lo.
  localparam int RAVENS_TS_HI_BITS  = 11;
  localparam int RAVENS_TS_MID_BITS = 30;
  localparam int RAVENS_TS_LO_BITS  = 6;

  localparam logic [1:0] RAVENS_MARK_W0 = 2'b01;
  localparam logic [1:0] RAVENS_MARK_W1 = 2'b10;
  localparam logic [1:0] RAVENS_MARK_W2 = 2'b11;

  // Marker field, common to all words.
  localparam int RAVENS_MARK_HI = 31;
  localparam int RAVENS_MARK_LO = 30;

  // Word 0 fields.
  localparam int RAVENS_W0_X_HI   = 29;
  localparam int RAVENS_W0_X_LO   = 21;
  localparam int RAVENS_W0_Y_HI   = 20;
  localparam int RAVENS_W0_Y_LO   = 12;
  localparam int RAVENS_W0_POL    = 11;
  localparam int RAVENS_W0_TSH_HI = 10;
  localparam int RAVENS_W0_TSH_LO = 0;

  // Word 1 fields.
  localparam int RAVENS_W1_TSM_HI = 29;
  localparam int RAVENS_W1_TSM_LO = 0;

  // Word 2 fields; the reserved bits must be zero.
  localparam int RAVENS_W2_TSL_HI  = 29;
  localparam int RAVENS_W2_TSL_LO  = 24;
  localparam int RAVENS_W2_RSVD_HI = 23;
  localparam int RAVENS_W2_RSVD_LO = 0;

  typedef struct packed {
    logic [DVS_X_ADDR_BITS-1:0]   x;
    logic [DVS_Y_ADDR_BITS-1:0]   y;
    logic                         pol;
    logic [TIMESTAMP_US_BITS-1:0] ts;
  } dvs_event_t;

  typedef enum logic [1:0] {
    S_W0 = 2'd0,
    S_W1 = 2'd1,
    S_W2 = 2'd2
  } ravens_dec_state_t;

  // Marker that a word must carry when it arrives in the given state.
  function automatic logic [1:0] ravens_expected_marker(input ravens_dec_state_t s);
    logic [1:0] m;
    case (s)
      S_W0:    m = RAVENS_MARK_W0;
      S_W1:    m = RAVENS_MARK_W1;
      S_W2:    m = RAVENS_MARK_W2;
      default: m = RAVENS_MARK_W0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ravens_pkt_decoder.sv
// Reassembles three-word RAVENS packets into DVS events (x, y, pol, ts).
// Optional marker/reserved-bit checking is compiled in with the macro
// RAVENS_DEC_CHECK_EN; without it assembly is purely positional and
// seq_err is held low.
//
// state | meaning
// S_W0  | waiting for word 0 (x, y, pol, ts hi)
// S_W1  | waiting for word 1 (ts mid)
// S_W2  | waiting for word 2 (ts lo); loads the output register
module ravens_pkt_decoder
  import dvs_ravens_pkg::*;
#(
  parameter int X_BITS  = DVS_X_ADDR_BITS,
  parameter int Y_BITS  = DVS_Y_ADDR_BITS,
  parameter int TS_BITS = TIMESTAMP_US_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RAVENS_PKT_BITS-1:0] pkt_data,
  input  logic                       pkt_valid,
  output logic                       pkt_ready,
  output logic [X_BITS-1:0]          event_x,
  output logic [Y_BITS-1:0]          event_y,
  output logic                       event_pol,
  output logic [TS_BITS-1:0]         event_ts,
  output logic                       event_valid,
  input  logic                       event_ready,
  output logic                       seq_err
);

  localparam int TS_HI_LSB  = TIMESTAMP_US_BITS - RAVENS_TS_HI_BITS;
  localparam int TS_MID_MSB = RAVENS_TS_LO_BITS + RAVENS_TS_MID_BITS - 1;

  ravens_dec_state_t state;
  dvs_event_t        part_q;
  dvs_event_t        evt_q;
  logic              event_valid_q;
  logic              seq_err_q;
  logic              pkt_xfer;
  logic              word_ok;
  logic              restart_w0;

  // Word 0 opens a fresh partial event; everything not carried by it is cleared.
  function automatic dvs_event_t load_w0(input logic [RAVENS_PKT_BITS-1:0] w);
    dvs_event_t e;
    e     = '0;
    e.x   = w[RAVENS_W0_X_HI:RAVENS_W0_X_LO];
    e.y   = w[RAVENS_W0_Y_HI:RAVENS_W0_Y_LO];
    e.pol = w[RAVENS_W0_POL];
    e.ts[TIMESTAMP_US_BITS-1:TS_HI_LSB] = w[RAVENS_W0_TSH_HI:RAVENS_W0_TSH_LO];
    return e;
  endfunction

  // Word 2 is only blocked while a held event is not being drained; reset
  // keeps the input open so the upstream never sees a stall across reset.
  assign pkt_ready = rst || (state != S_W2) || !event_valid_q || event_ready;
  assign pkt_xfer  = pkt_valid && pkt_ready;

`ifdef RAVENS_DEC_CHECK_EN
  logic [1:0] pkt_marker;
  logic       marker_ok;
  logic       rsvd_ok;

  assign pkt_marker = pkt_data[RAVENS_MARK_HI:RAVENS_MARK_LO];
  assign marker_ok  = (pkt_marker == ravens_expected_marker(state));
  assign rsvd_ok    = (state != S_W2) ||
                      (pkt_data[RAVENS_W2_RSVD_HI:RAVENS_W2_RSVD_LO] == '0);
  assign word_ok    = marker_ok && rsvd_ok;
  // A stray word-0 marker is most likely the start of the next event, so
  // resynchronise on it rather than dropping it too.
  assign restart_w0 = !marker_ok && (pkt_marker == RAVENS_MARK_W0);
`else
  logic unused_pkt_bits;

  assign unused_pkt_bits = ^{pkt_data[RAVENS_MARK_HI:RAVENS_MARK_LO],
                             pkt_data[RAVENS_W2_RSVD_HI:RAVENS_W2_RSVD_LO]};
  assign word_ok    = 1'b1;
  assign restart_w0 = 1'b0;
`endif

  // Word sequencing, partial capture, output register and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_W0;
      part_q        <= '0;
      evt_q         <= '0;
      event_valid_q <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      seq_err_q <= 1'b0;
      if (event_valid_q && event_ready) begin
        event_valid_q <= 1'b0;
      end
      if (pkt_xfer) begin
        if (!word_ok) begin
          seq_err_q <= 1'b1;
          if (restart_w0) begin
            part_q <= load_w0(pkt_data);
            state  <= S_W1;
          end else begin
            part_q <= '0;
            state  <= S_W0;
          end
        end else begin
          unique case (state)
            S_W0: begin
              part_q <= load_w0(pkt_data);
              state  <= S_W1;
            end
            S_W1: begin
              part_q.ts[TS_MID_MSB:RAVENS_TS_LO_BITS] <=
                pkt_data[RAVENS_W1_TSM_HI:RAVENS_W1_TSM_LO];
              state <= S_W2;
            end
            S_W2: begin
              evt_q <= part_q;
              evt_q.ts[RAVENS_TS_LO_BITS-1:0] <=
                pkt_data[RAVENS_W2_TSL_HI:RAVENS_W2_TSL_LO];
              event_valid_q <= 1'b1;
              state         <= S_W0;
            end
            default: begin
              part_q <= '0;
              state  <= S_W0;
            end
          endcase
        end
      end
    end
  end

  assign event_x     = X_BITS'(evt_q.x);
  assign event_y     = Y_BITS'(evt_q.y);
  assign event_pol   = evt_q.pol;
  assign event_ts    = TS_BITS'(evt_q.ts);
  assign event_valid = event_valid_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_ravens_pkt_decoder.sv
// Directed + randomized bench for ravens_pkt_decoder. Expected events come
// from a queue filled with the events the bench encodes; the encoder below
// builds words with plain arithmetic from the packet format.
module tb_ravens_pkt_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pkt_data = '0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [8:0]  event_x;
  logic [8:0]  event_y;
  logic        event_pol;
  logic [46:0] event_ts;
  logic        event_valid;
  logic        event_ready = 1'b1;
  logic        seq_err;

  ravens_pkt_decoder dut (
    .clk(clk), .rst(rst),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .event_x(event_x), .event_y(event_y), .event_pol(event_pol),
    .event_ts(event_ts), .event_valid(event_valid),
    .event_ready(event_ready), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  x;
    logic [8:0]  y;
    logic        pol;
    logic [46:0] ts;
  } ev_t;

  int      checks = 0;
  int      errors = 0;
  longint  cyc = 0;
  int      seq_err_cnt = 0;
  int      ev_cnt = 0;
  ev_t     exp_q[$];
  longint  hs_cyc[$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] enc_w0(input ev_t e);
    logic [63:0] v;
    v = 64'h4000_0000 + (64'(e.x) << 21) + (64'(e.y) << 12) + (64'(e.pol) << 11)
        + (64'(e.ts) >> 36);
    return v[31:0];
  endfunction

  function automatic logic [31:0] enc_w1(input ev_t e);
    logic [63:0] v;
    v = 64'h8000_0000 + ((64'(e.ts) >> 6) % 64'h4000_0000);
    return v[31:0];
  endfunction

  function automatic logic [31:0] enc_w2(input ev_t e);
    logic [63:0] v;
    v = 64'hC000_0000 + ((64'(e.ts) % 64) << 24);
    return v[31:0];
  endfunction

  function automatic ev_t rand_ev();
    ev_t e;
    logic [63:0] r;
    r     = {$urandom, $urandom};
    e.x   = 9'($urandom_range(0, 511));
    e.y   = 9'($urandom_range(0, 511));
    e.pol = 1'($urandom_range(0, 1));
    e.ts  = r[46:0];
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every held or accepted event must match the model's head.
  always @(negedge clk) begin
    if (seq_err === 1'b1) seq_err_cnt++;
    if (rst === 1'b0 && event_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 64'(event_valid), 64'd0);
      end else begin
        chk("event_x",   64'(event_x),   64'(exp_q[0].x));
        chk("event_y",   64'(event_y),   64'(exp_q[0].y));
        chk("event_pol", 64'(event_pol), 64'(exp_q[0].pol));
        chk("event_ts",  64'(event_ts),  64'(exp_q[0].ts));
        if (event_ready === 1'b1) begin
          hs_cyc.push_back(cyc);
          ev_cnt++;
          exp_q.delete(0);
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    pkt_data  = w;
    pkt_valid = 1'b1;
    @(negedge clk);
    while (pkt_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("pkt_accept_timeout", 64'(pkt_ready), 64'd1);
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
  endtask

  task automatic send_ev(input ev_t e);
    send_word(enc_w0(e));
    send_word(enc_w1(e));
    send_word(enc_w2(e));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t e;
    ev_t e2;
    ev_t big;
    logic stall_ok;
    int base_ev;
    int base_se;

    big.x = 9'd345; big.y = 9'd259; big.pol = 1'b1; big.ts = 47'h7FFF_FFFF_FFFF;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", 64'(pkt_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid",   64'(event_valid), 64'd0);
    chk("rst_seq_err", 64'(seq_err),     64'd0);
    chk("rst_x",       64'(event_x),     64'd0);
    chk("rst_ts",      64'(event_ts),    64'd0);
    chk("rst_ready",   64'(pkt_ready),   64'd1);
    @(posedge clk);
    #1;

    // Single known event and one-cycle latency.
    exp_q.push_back(big);
    send_word(32'h6B30_3FFF);
    send_word(32'hBFFF_FFFF);
    pkt_data  = 32'hFF00_0000;
    pkt_valid = 1'b1;
    @(negedge clk);
    chk("w2_pre_valid", 64'(event_valid), 64'd0);
    @(posedge clk);
    #1 pkt_valid = 1'b0;
    chk("latency_valid", 64'(event_valid), 64'd1);
    wait_drain();

    // Ten random events back to back.
    hs_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      e = rand_ev();
      exp_q.push_back(e);
      send_ev(e);
    end
    wait_drain();
    chk("stream_count", 64'(hs_cyc.size()), 64'd10);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("stream_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd3);

    // Output back-pressure: word 2 of the second event stalls.
    event_ready = 1'b0;
    e  = rand_ev();
    e2 = rand_ev();
    exp_q.push_back(e);
    send_ev(e);
    exp_q.push_back(e2);
    send_word(enc_w0(e2));
    send_word(enc_w1(e2));
    pkt_data  = enc_w2(e2);
    pkt_valid = 1'b1;
    stall_ok  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pkt_ready !== 1'b0) stall_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("w2_stall", 64'(stall_ok), 64'd1);
    event_ready = 1'b1;
    @(negedge clk);
    chk("w2_release_ready", 64'(pkt_ready), 64'd1);
    @(posedge clk);
    #1 pkt_valid = 1'b0;
    chk("load_and_drain_valid", 64'(event_valid), 64'd1);
    wait_drain();

    // Reset with a held event and a partial event in flight.
    event_ready = 1'b0;
    e = rand_ev();
    exp_q.push_back(e);
    send_ev(e);
    e2 = rand_ev();
    send_word(enc_w0(e2));
    send_word(enc_w1(e2));
    rst = 1'b1;
    @(negedge clk);
    chk("ready_mid_reset", 64'(pkt_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    chk("reset_drops_event", 64'(event_valid), 64'd0);
    event_ready = 1'b1;
    base_ev = ev_cnt;
    e = rand_ev();
    exp_q.push_back(e);
    send_ev(e);
    wait_drain();
    chk("post_reset_events", 64'(ev_cnt - base_ev), 64'd1);

`ifdef RAVENS_DEC_CHECK_EN
    // Repeated word 0 resynchronises.
    base_ev = ev_cnt;
    base_se = seq_err_cnt;
    exp_q.push_back(big);
    send_word(32'h6B30_3FFF);
    send_word(32'h6B30_3FFF);
    send_word(32'hBFFF_FFFF);
    send_word(32'hFF00_0000);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    chk("dup_w0_seq_err", 64'(seq_err_cnt - base_se), 64'd1);
    chk("dup_w0_events",  64'(ev_cnt - base_ev),      64'd1);

    // Nonzero reserved bits drop the event.
    base_ev = ev_cnt;
    base_se = seq_err_cnt;
    send_word(32'h6B30_3FFF);
    send_word(32'hBFFF_FFFF);
    send_word(32'hFF00_0001);
    repeat (4) @(posedge clk);
    #1;
    chk("rsvd_seq_err", 64'(seq_err_cnt - base_se), 64'd1);
    chk("rsvd_events",  64'(ev_cnt - base_ev),      64'd0);
    chk("rsvd_valid",   64'(event_valid),           64'd0);
`else
    // Reserved bits are ignored when checking is not built in.
    base_ev = ev_cnt;
    exp_q.push_back(big);
    send_word(32'h6B30_3FFF);
    send_word(32'hBFFF_FFFF);
    send_word(32'hFF00_0001);
    wait_drain();
    chk("rsvd_ignored_events", 64'(ev_cnt - base_ev), 64'd1);
    chk("seq_err_never",       64'(seq_err_cnt),      64'd0);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
